alu_issue: RTL and testbench

Sequencing stage directly upstream of the combinational ALU.
- Accepts one operation request per transaction over a valid/ready handshake.
- Reads two operands from a small internal register file and drives the ALU's F/a/b inputs.
- Captures the ALU result and carry-out, writes the result back to the register file, and presents it on a valid/ready response port.
- Turns the stateless ALU into a usable register-to-register execute unit.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_regfile.sv | 60 ++++++
 rtl/alu_issue.sv | 166 ++++++++++++++++
 tb/tb_alu_issue.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// Module   : alu_pkg
// Purpose  : ALU function codes and issue-stage state encoding.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_RSVD = 3'd3;
    localparam logic [2:0] OP_ANDN = 3'd4;
    localparam logic [2:0] OP_ORN  = 3'd5;
    localparam logic [2:0] OP_SUB  = 3'd6;
    localparam logic [2:0] OP_SLT  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_regfile.sv
//------------------------------------------------------------------------------
// Module   : alu_regfile
// Purpose  : REGS x N register file, R0 hardwired zero, 2 read / 1 write port
//            with writeback taking priority over the direct load strobe.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_regfile #(
    parameter int N    = 8,
    parameter int REGS = 4,
    parameter int AW   = $clog2(REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] i_ra1,
    input  logic [AW-1:0] i_ra2,
    output logic [N-1:0]  o_rd1,
    output logic [N-1:0]  o_rd2,
    input  logic          i_wb_en,
    input  logic [AW-1:0] i_wb_addr,
    input  logic [N-1:0]  i_wb_data,
    input  logic          i_ld_en,
    input  logic [AW-1:0] i_ld_addr,
    input  logic [N-1:0]  i_ld_data
);

    logic [N-1:0] w_rf [REGS];

    assign w_rf[0] = '0;

    generate
        for (genvar gi = 1; gi < REGS; gi++) begin : g_entry
            logic [N-1:0] r_q;
            logic         w_wb_hit;
            logic         w_ld_hit;

            assign w_wb_hit = i_wb_en && (i_wb_addr == AW'(gi));
            assign w_ld_hit = i_ld_en && (i_ld_addr == AW'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (w_wb_hit) begin
                    r_q <= i_wb_data;
                end else if (w_ld_hit) begin
                    r_q <= i_ld_data;
                end
            end

            assign w_rf[gi] = r_q;
        end
    endgenerate

    assign o_rd1 = w_rf[i_ra1];
    assign o_rd2 = w_rf[i_ra2];

endmodule

`default_nettype wire

// File: rtl/alu_issue.sv
//------------------------------------------------------------------------------
// Module   : alu_issue
// Purpose  : Register-to-register issue/writeback stage around a combinational
//            ALU. Optional macro ALU_ISSUE_ZERO_FLAG_EN adds output out_zero.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_issue
    import alu_pkg::*;
#(
    parameter int N    = 8,
    parameter int REGS = 4,
    parameter int AW   = $clog2(REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [N-1:0]  ld_data,
    output logic [2:0]    alu_F,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    input  logic [N-1:0]  alu_y,
    input  logic          alu_cout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          out_cout,
    output logic [AW-1:0] out_rd,
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    output logic          out_zero,
`endif
    output logic          out_err
);

    state_t        r_state;
    state_t        w_next_state;
    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_accept;
    logic          w_wb_en;
    logic [N-1:0]  w_rs1_data;
    logic [N-1:0]  w_rs2_data;

    logic [2:0]    r_alu_F;
    logic [N-1:0]  r_alu_a;
    logic [N-1:0]  r_alu_b;
    logic [AW-1:0] r_rd;
    logic [N-1:0]  r_out_data;
    logic          r_out_cout;
    logic [AW-1:0] r_out_rd;
    logic          r_out_err;

    assign w_accept = in_valid && w_in_ready;
    // Illegal ops and R0 targets still produce a response but never write back.
    assign w_wb_en  = (r_state == EXEC) && (r_alu_F != OP_RSVD) && (r_rd != '0);

    alu_regfile #(
        .N    (N),
        .REGS (REGS),
        .AW   (AW)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_ra1     (in_rs1),
        .i_ra2     (in_rs2),
        .o_rd1     (w_rs1_data),
        .o_rd2     (w_rs2_data),
        .i_wb_en   (w_wb_en),
        .i_wb_addr (r_rd),
        .i_wb_data (alu_y),
        .i_ld_en   (ld_en),
        .i_ld_addr (ld_addr),
        .i_ld_data (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next_state = EXEC;
            EXEC:    w_next_state = RESP;
            RESP:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE:    w_in_ready  = 1'b1;
            RESP:    w_out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_F <= '0;
            r_alu_a <= '0;
            r_alu_b <= '0;
            r_rd    <= '0;
        end else if (w_accept) begin
            r_alu_F <= in_op;
            r_alu_a <= w_rs1_data;
            r_alu_b <= w_rs2_data;
            r_rd    <= in_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data <= '0;
            r_out_cout <= 1'b0;
            r_out_rd   <= '0;
            r_out_err  <= 1'b0;
        end else if (r_state == EXEC) begin
            r_out_data <= alu_y;
            r_out_cout <= alu_cout;
            r_out_rd   <= r_rd;
            r_out_err  <= (r_alu_F == OP_RSVD);
        end
    end

`ifdef ALU_ISSUE_ZERO_FLAG_EN
    logic r_out_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_zero <= 1'b0;
        end else if (r_state == EXEC) begin
            r_out_zero <= (alu_y == '0);
        end
    end

    assign out_zero = r_out_zero;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign alu_F     = r_alu_F;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign out_data  = r_out_data;
    assign out_cout  = r_out_cout;
    assign out_rd    = r_out_rd;
    assign out_err   = r_out_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_issue
// Purpose  : Self-checking bench for alu_issue with an attached ALU model and
//            an array-based register-file reference.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_issue;

    localparam int N    = 8;
    localparam int REGS = 4;
    localparam int AW   = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [AW-1:0] in_rd;
    logic [AW-1:0] in_rs1;
    logic [AW-1:0] in_rs2;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [N-1:0]  ld_data;
    logic [2:0]    alu_F;
    logic [N-1:0]  alu_a;
    logic [N-1:0]  alu_b;
    logic [N-1:0]  alu_y;
    logic          alu_cout;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          out_cout;
    logic [AW-1:0] out_rd;
    logic          out_err;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    logic          out_zero;
`endif

    int checks   = 0;
    int failures = 0;
    logic [N-1:0] model [REGS];

    always #5 clk = ~clk;

    alu_issue #(.N(N), .REGS(REGS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .alu_F     (alu_F),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_y     (alu_y),
        .alu_cout  (alu_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cout  (out_cout),
        .out_rd    (out_rd),
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        .out_zero  (out_zero),
`endif
        .out_err   (out_err)
    );

    // Reference ALU: {cout, y}
    function automatic logic [N:0] alu_ref(input logic [2:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] d;
        case (f)
            3'd0: return {1'b0, a & b};
            3'd1: return {1'b0, a | b};
            3'd2: return {1'b0, a} + {1'b0, b};
            3'd4: return {1'b0, a & ~b};
            3'd5: return {1'b0, a | ~b};
            3'd6: return {1'b0, a} + {1'b0, ~b} + 1;
            3'd7: begin
                d = {1'b0, a} - {1'b0, b};
                return {1'b0, {(N-1){1'b0}}, d[N-1]};
            end
            default: return '0;
        endcase
    endfunction

    always_comb begin
        logic [N:0] r;
        r        = alu_ref(alu_F, alu_a, alu_b);
        alu_y    = r[N-1:0];
        alu_cout = r[N];
    end

    task automatic do_load(input logic [AW-1:0] a, input logic [N-1:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
        if (a != 0) model[a] = d;
    endtask

    // ld_ph: 0 = no load, 1 = load on the accept edge, 2 = load on the writeback edge
    task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                         input logic [AW-1:0] rs2, input int hold, input int ld_ph,
                         input logic [AW-1:0] la, input logic [N-1:0] ldv);
        logic [N-1:0] a, b, ey;
        logic [N:0]   r;
        logic         ec, eerr;
        a = model[rs1]; b = model[rs2];
        r = alu_ref(op, a, b); ey = r[N-1:0]; ec = r[N]; eerr = (op == 3'd3);

        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        if (ld_ph == 1) begin ld_en = 1'b1; ld_addr = la; ld_data = ldv; end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end

        @(negedge clk);
        in_valid = 1'b0; ld_en = 1'b0;
        if (ld_ph == 1 && la != 0) model[la] = ldv;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL exec_handshake got valid=%b ready=%b exp valid=0 ready=0", out_valid, in_ready);
        end
        checks++;
        if (alu_F !== op || alu_a !== a || alu_b !== b) begin
            failures++; $display("FAIL alu_drive got F=%h a=%h b=%h exp F=%h a=%h b=%h", alu_F, alu_a, alu_b, op, a, b);
        end
        if (ld_ph == 2) begin ld_en = 1'b1; ld_addr = la; ld_data = ldv; end

        @(negedge clk);
        ld_en = 1'b0;
        if (ld_ph == 2 && la != 0) model[la] = ldv;
        if (!eerr && rd != 0) model[rd] = ey;
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL resp_valid got=%b exp=1", out_valid); end
        checks++;
        if (out_data !== ey || out_cout !== ec || out_rd !== rd || out_err !== eerr) begin
            failures++;
            $display("FAIL resp_fields op=%0d got data=%h c=%b rd=%0d err=%b exp data=%h c=%b rd=%0d err=%b",
                     op, out_data, out_cout, out_rd, out_err, ey, ec, rd, eerr);
        end
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        checks++;
        if (out_zero !== (ey == '0)) begin failures++; $display("FAIL resp_zero got=%b exp=%b", out_zero, (ey == '0)); end
`endif

        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== ey || out_cout !== ec || out_rd !== rd || out_err !== eerr) begin
                failures++;
                $display("FAIL resp_hold cyc=%0d got v=%b rdy=%b data=%h exp v=1 rdy=0 data=%h", k, out_valid, in_ready, out_data, ey);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL resp_done got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_hs got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid);
        end
        checks++;
        if (alu_F !== 3'd0 || alu_a !== '0 || alu_b !== '0 || out_data !== '0 || out_cout !== 1'b0 || out_rd !== '0 || out_err !== 1'b0) begin
            failures++; $display("FAIL reset_regs got F=%h a=%h b=%h data=%h exp all zero", alu_F, alu_a, alu_b, out_data);
        end
        rst_n = 1'b1;
        for (int i = 0; i < REGS; i++) model[i] = '0;
    endtask

    task automatic test_basic();
        do_load(2'd1, 8'd2);
        do_load(2'd2, 8'd3);
        issue(3'd2, 2'd3, 2'd1, 2'd2, 0, 0, 2'd0, 8'd0);   // ADD -> 5
        issue(3'd1, 2'd0, 2'd3, 2'd3, 0, 0, 2'd0, 8'd0);   // read R3
        issue(3'd6, 2'd3, 2'd1, 2'd2, 0, 0, 2'd0, 8'd0);   // SUB -> FF
        issue(3'd7, 2'd3, 2'd1, 2'd2, 0, 0, 2'd0, 8'd0);   // SLT -> 1
    endtask

    task automatic test_carry_zero();
        do_load(2'd1, 8'hFF);
        do_load(2'd2, 8'd1);
        issue(3'd2, 2'd3, 2'd1, 2'd2, 0, 0, 2'd0, 8'd0);
    endtask

    task automatic test_r0_and_illegal();
        do_load(2'd1, 8'd2);
        do_load(2'd2, 8'd3);
        do_load(2'd0, 8'h5A);
        issue(3'd2, 2'd0, 2'd1, 2'd2, 0, 0, 2'd0, 8'd0);
        issue(3'd1, 2'd3, 2'd0, 2'd0, 0, 0, 2'd0, 8'd0);   // R0|R0 must be 0
        issue(3'd3, 2'd3, 2'd1, 2'd2, 0, 0, 2'd0, 8'd0);   // illegal, no writeback
        issue(3'd1, 2'd0, 2'd3, 2'd3, 0, 0, 2'd0, 8'd0);
    endtask

    task automatic test_backpressure();
        issue(3'd2, 2'd1, 2'd1, 2'd2, 5, 0, 2'd0, 8'd0);
        issue(3'd0, 2'd2, 2'd1, 2'd1, 0, 0, 2'd0, 8'd0);
    endtask

    task automatic test_load_collisions();
        issue(3'd2, 2'd3, 2'd1, 2'd2, 0, 1, 2'd1, 8'h40);  // load on accept not seen
        issue(3'd2, 2'd3, 2'd1, 2'd2, 0, 2, 2'd3, 8'h77);  // writeback beats load
        issue(3'd1, 2'd0, 2'd3, 2'd1, 0, 2, 2'd2, 8'h11);  // load lands while rd=0
        issue(3'd1, 2'd0, 2'd2, 2'd3, 0, 0, 2'd0, 8'd0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1)
                do_load(AW'($urandom_range(0, REGS-1)), N'($urandom));
            issue(3'($urandom_range(0, 7)), AW'($urandom_range(0, REGS-1)), AW'($urandom_range(0, REGS-1)),
                  AW'($urandom_range(0, REGS-1)), $urandom_range(0, 2), $urandom_range(0, 2),
                  AW'($urandom_range(0, REGS-1)), N'($urandom));
        end
    endtask

    task automatic test_reset_mid_exec();
        do_load(2'd1, 8'd9);
        do_load(2'd2, 8'd4);
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd2; in_rd = 2'd3; in_rs1 = 2'd1; in_rs2 = 2'd2;
        @(negedge clk);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL midrst_hs got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid);
        end
        for (int i = 0; i < REGS; i++) model[i] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_novalid cyc=%0d got=%b exp=0", k, out_valid); end
        end
        issue(3'd1, 2'd0, 2'd1, 2'd2, 0, 0, 2'd0, 8'd0);
        issue(3'd1, 2'd0, 2'd3, 2'd3, 0, 0, 2'd0, 8'd0);
    endtask

    initial begin
        in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_carry_zero();
        test_r0_and_illegal();
        test_backpressure();
        test_load_collisions();
        test_back_to_back();
        test_reset_mid_exec();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
